// File: rtl/tcl_pkg.sv
// Shared widths and FSM encoding for the transaction-layer transmit merge.
package tcl_pkg;
    localparam int DATA_W    = 12;
    localparam int NUM_PORTS = 4;
    localparam int DEPTH     = 4;
    localparam int CNT_W     = 5;
    localparam int OCC_W     = 3;   // occupancy and thresholds share this width
    localparam int PTR_W     = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE} state_t;
endpackage

// File: rtl/tcl_tx_merge_if.sv
// Upstream push ports and merged downstream stream of the transmit merge.
interface tcl_tx_merge_if;
    logic [tcl_pkg::NUM_PORTS-1:0] pushIn;
    logic [tcl_pkg::DATA_W-1:0]    dataInputP0;
    logic [tcl_pkg::DATA_W-1:0]    dataInputP1;
    logic [tcl_pkg::DATA_W-1:0]    dataInputP2;
    logic [tcl_pkg::DATA_W-1:0]    dataInputP3;
    logic                          pauseIn;
    logic                          pushOut;
    logic [tcl_pkg::DATA_W-1:0]    dataOutputFIFO;

    modport master (output pushIn, dataInputP0, dataInputP1, dataInputP2, dataInputP3, pauseIn,
                    input  pushOut, dataOutputFIFO);
    modport slave  (input  pushIn, dataInputP0, dataInputP1, dataInputP2, dataInputP3, pauseIn,
                    output pushOut, dataOutputFIFO);
endinterface

// File: rtl/tcl_tx_fifo.sv
// Per-port synchronous FIFO; a push while full is dropped and flagged on o_drop.
module tcl_tx_fifo
    import tcl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic [OCC_W-1:0]  o_occ,
    output logic [OCC_W-1:0]  o_occ_nxt,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_drop
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr, r_rd;
    logic [OCC_W-1:0]  r_occ;
    logic              w_wr, w_rd;

    // Full is judged on current occupancy, so a same-cycle pop never rescues a push.
    assign o_full    = (r_occ == OCC_W'(DEPTH));
    assign o_empty   = (r_occ == '0);
    assign w_wr      = i_push && !o_full;
    assign w_rd      = i_pop && !o_empty;
    assign o_drop    = i_push && o_full;
    assign o_data    = r_mem[r_rd];
    assign o_occ     = r_occ;
    assign o_occ_nxt = r_occ + OCC_W'(w_wr) - OCC_W'(w_rd);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_occ <= '0;
        end else begin
            if (w_wr) r_wr <= r_wr + 1'b1;
            if (w_rd) r_rd <= r_rd + 1'b1;
            r_occ <= o_occ_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/tcl_tx_merge.sv
// 4-to-1 transmit merge: per-port FIFOs, arbiter, hysteretic flags, sent-word counters.
// Define TCL_TX_STRICT_PRIO_EN for fixed P0>P1>P2>P3 priority instead of round-robin.
module tcl_tx_merge
    import tcl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [2:0]           Umbral_alto,
    input  logic [2:0]           Umbral_bajo,
    tcl_tx_merge_if.slave        bus,
    output logic [NUM_PORTS-1:0] fullP,
    output logic [NUM_PORTS-1:0] almostFullP,
    output logic                 errorOut,
    output logic                 idleOut,
    input  logic                 req,
    input  logic [2:0]           idx,
    output logic                 counterValid,
    output logic [CNT_W-1:0]     counterOut
);
    state_t                              r_state, w_state_nxt;
    logic [NUM_PORTS-1:0][DATA_W-1:0]    w_din, w_dout;
    logic [NUM_PORTS-1:0][OCC_W-1:0]     w_occ, w_occ_nxt;
    logic [NUM_PORTS-1:0]                w_push, w_pop, w_full, w_empty, w_drop;
    logic [NUM_PORTS-1:0][CNT_W-1:0]     r_cnt;
    logic [NUM_PORTS-1:0]                r_af;
    logic [2:0]                          r_alto, r_bajo;
    logic [PTR_W-1:0]                    w_win;
    logic                                w_found, w_gnt, w_run;
    logic                                r_push_out, r_err, r_cv;
    logic [DATA_W-1:0]                   r_data_out;
    logic [CNT_W-1:0]                    r_co;

    assign w_din  = {bus.dataInputP3, bus.dataInputP2, bus.dataInputP1, bus.dataInputP0};
    assign w_run  = (r_state == ST_IDLE) || (r_state == ST_ACTIVE);
    assign w_push = bus.pushIn & {NUM_PORTS{r_state != ST_RESET}};

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_fifo
        tcl_tx_fifo u_fifo (
            .clk(clk), .reset(reset), .i_push(w_push[g]), .i_pop(w_pop[g]), .i_data(w_din[g]),
            .o_data(w_dout[g]), .o_occ(w_occ[g]), .o_occ_nxt(w_occ_nxt[g]),
            .o_full(w_full[g]), .o_empty(w_empty[g]), .o_drop(w_drop[g])
        );
    end

`ifdef TCL_TX_STRICT_PRIO_EN
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        // Scan downward so the lowest non-empty port is the last one written.
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (!w_empty[k]) begin
                w_win   = PTR_W'(k);
                w_found = 1'b1;
            end
        end
    end
`else
    logic [PTR_W-1:0] r_ptr, w_cand;

    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            w_cand = r_ptr + PTR_W'(k);
            if (!w_found && !w_empty[w_cand]) begin
                w_win   = w_cand;
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)      r_ptr <= PTR_W'(NUM_PORTS - 1);
        else if (w_gnt) r_ptr <= w_win;
    end
`endif

    always_comb begin
        w_gnt = w_found && w_run && !bus.pauseIn;
        w_pop = '0;
        if (w_gnt) w_pop[w_win] = 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RESET:  w_state_nxt = ST_INIT;
            ST_INIT:   if (!init) w_state_nxt = ST_IDLE;
            ST_IDLE:   if (init) w_state_nxt = ST_INIT;
                       else if (!(&w_empty)) w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (init) w_state_nxt = ST_INIT;
                       else if ((&w_empty) && !w_gnt) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_RESET;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alto     <= 3'd7;
            r_bajo     <= 3'd0;
            r_af       <= '0;
            r_cnt      <= '0;
            r_push_out <= 1'b0;
            r_data_out <= '0;
            r_err      <= 1'b0;
            r_cv       <= 1'b0;
            r_co       <= '0;
        end else begin
            if (r_state == ST_INIT) begin
                r_alto <= Umbral_alto;
                r_bajo <= Umbral_bajo;
            end
            // Set test first so it wins when the clear window overlaps.
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_occ_nxt[i] >= r_alto)      r_af[i] <= 1'b1;
                else if (w_occ_nxt[i] <= r_bajo) r_af[i] <= 1'b0;
                if (w_pop[i]) r_cnt[i] <= r_cnt[i] + 1'b1;
            end
            r_push_out <= w_gnt;
            if (w_gnt) r_data_out <= w_dout[w_win];
            r_err <= r_err | (|w_drop);
            r_cv  <= req && w_run;
            if (req && w_run)
                r_co <= (idx < 3'(NUM_PORTS)) ? r_cnt[idx[PTR_W-1:0]] : '0;
        end
    end

    assign bus.pushOut        = r_push_out;
    assign bus.dataOutputFIFO = r_data_out;
    assign fullP              = w_full;
    assign almostFullP        = r_af;
    assign errorOut           = r_err;
    assign idleOut            = (r_state == ST_IDLE);
    assign counterValid       = r_cv;
    assign counterOut         = r_co;
endmodule

// File: tb/tb_tcl_tx_merge.sv
// Self-checking bench for tcl_tx_merge: burst vector table, scoreboard on the merged stream.
module tb_tcl_tx_merge;
    logic       clk = 1'b0;
    logic       reset, init, req;
    logic [2:0] Umbral_alto, Umbral_bajo, idx;
    logic [3:0] fullP, almostFullP;
    logic       errorOut, idleOut, counterValid;
    logic [4:0] counterOut;

    tcl_tx_merge_if bus();

    tcl_tx_merge dut (
        .clk(clk), .reset(reset), .init(init), .Umbral_alto(Umbral_alto), .Umbral_bajo(Umbral_bajo),
        .bus(bus), .fullP(fullP), .almostFullP(almostFullP), .errorOut(errorOut), .idleOut(idleOut),
        .req(req), .idx(idx), .counterValid(counterValid), .counterOut(counterOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]        mask;
        logic [3:0][11:0]  d;
        logic [3:0][11:0]  er;   // expected order, round-robin
        logic [3:0][11:0]  es;   // expected order, strict priority
        int                n;
    } vec_t;

    typedef struct {
        logic [2:0] idx;
        logic [4:0] cnt;
    } rd_t;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [11:0] sb[$];
    vec_t        vt[6];
    rd_t         rt[5];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Every edge: any merged word must match the head of the scoreboard.
    task automatic tick();
        logic [11:0] e;
        @(posedge clk);
        #1;
        if (bus.pushOut === 1'b1) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got word %0h, required no output", bus.dataOutputFIFO);
            end else begin
                e = sb.pop_front();
                if (bus.dataOutputFIFO !== e) begin
                    n_fail++;
                    $display("FAIL sb_data: got %0h, required %0h", bus.dataOutputFIFO, e);
                end
            end
        end
    endtask

    task automatic wait_drain(string nm);
        for (int t = 0; t < 60 && !(sb.size() == 0 && idleOut === 1'b1); t++) tick();
        chk(nm, {sb.size() == 0, idleOut}, 2'b11);
    endtask

    task automatic do_init();
        init = 1'b1;
        tick();
        tick();
        init = 1'b0;
        tick();
    endtask

    task automatic read_cnt(string nm, logic [2:0] i, logic [4:0] exp);
        req = 1'b1;
        idx = i;
        tick();
        chk({nm, "_valid"}, counterValid, 1);
        chk({nm, "_value"}, counterOut, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        vt[0] = '{4'b1111, {12'h404, 12'h303, 12'h202, 12'h101},
                  {12'h404, 12'h303, 12'h202, 12'h101}, {12'h404, 12'h303, 12'h202, 12'h101}, 4};
        vt[1] = '{4'b0101, {12'h000, 12'h0A3, 12'h000, 12'h0A1},
                  {12'h000, 12'h000, 12'h0A3, 12'h0A1}, {12'h000, 12'h000, 12'h0A3, 12'h0A1}, 2};
        vt[2] = '{4'b1011, {12'hB13, 12'h000, 12'hB11, 12'hB10},
                  {12'h000, 12'hB11, 12'hB10, 12'hB13}, {12'h000, 12'hB13, 12'hB11, 12'hB10}, 3};
        vt[3] = '{4'b1100, {12'hC33, 12'hC22, 12'h000, 12'h000},
                  {12'h000, 12'h000, 12'hC33, 12'hC22}, {12'h000, 12'h000, 12'hC33, 12'hC22}, 2};
        vt[4] = '{4'b0010, {12'h000, 12'h000, 12'hFFF, 12'h000},
                  {12'h000, 12'h000, 12'h000, 12'hFFF}, {12'h000, 12'h000, 12'h000, 12'hFFF}, 1};
        vt[5] = '{4'b1001, {12'h5A5, 12'h000, 12'h000, 12'h050},
                  {12'h000, 12'h000, 12'h050, 12'h5A5}, {12'h000, 12'h000, 12'h5A5, 12'h050}, 2};
        rt[0] = '{3'd3, 5'd1};
        rt[1] = '{3'd5, 5'd0};
        rt[2] = '{3'd0, 5'd0};
        rt[3] = '{3'd2, 5'd0};
        rt[4] = '{3'd7, 5'd0};

        reset = 1'b1; init = 1'b0; req = 1'b0; idx = '0;
        Umbral_alto = 3'd3; Umbral_bajo = 3'd1;
        bus.pushIn = '0; bus.pauseIn = 1'b0;
        bus.dataInputP0 = '0; bus.dataInputP1 = '0; bus.dataInputP2 = '0; bus.dataInputP3 = '0;
        tick();
        tick();
        chk("rst_pushOut", bus.pushOut, 0);
        chk("rst_data", bus.dataOutputFIFO, 0);
        chk("rst_fullP", fullP, 0);
        chk("rst_afull", almostFullP, 0);
        chk("rst_error", errorOut, 0);
        chk("rst_idle", idleOut, 0);
        chk("rst_cvalid", counterValid, 0);
        chk("rst_cout", counterOut, 0);

        // RESET -> INIT, two INIT cycles with a counter request that must be ignored.
        reset = 1'b0; init = 1'b1;
        tick();
        chk("init_idle", idleOut, 0);
        req = 1'b1;
        tick();
        tick();
        chk("init_req_ignored", counterValid, 0);
        req = 1'b0; init = 1'b0;
        tick();
        chk("idle_after_init", idleOut, 1);
        chk("idle_pushOut", bus.pushOut, 0);

        for (int i = 0; i < 6; i++) begin
            bus.pushIn = vt[i].mask;
            bus.dataInputP0 = vt[i].d[0]; bus.dataInputP1 = vt[i].d[1];
            bus.dataInputP2 = vt[i].d[2]; bus.dataInputP3 = vt[i].d[3];
            for (int j = 0; j < vt[i].n; j++) begin
`ifdef TCL_TX_STRICT_PRIO_EN
                sb.push_back(vt[i].es[j]);
`else
                sb.push_back(vt[i].er[j]);
`endif
            end
            tick();
            bus.pushIn = '0;
            chk("vec_latency", bus.pushOut, 0);
            tick();
            chk("vec_first", bus.pushOut, 1);
            wait_drain("vec_drain");
        end

        // Fill P2 under pause, overflow it, then drain through the hysteresis window.
        bus.pauseIn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.pushIn = 4'b0100;
            bus.dataInputP2 = 12'h2A0 + 12'(k);
            tick();
            if (k == 1) chk("af_occ2", almostFullP[2], 0);
            if (k == 2) begin
                chk("af_occ3", almostFullP[2], 1);
                chk("full_occ3", fullP[2], 0);
            end
            if (k == 3) begin
                chk("full_occ4", fullP[2], 1);
                chk("err_before", errorOut, 0);
            end
        end
        bus.dataInputP2 = 12'h2FF;
        tick();
        bus.pushIn = '0;
        chk("err_overflow", errorOut, 1);
        chk("full_hold", fullP[2], 1);
        for (int k = 0; k < 4; k++) sb.push_back(12'h2A0 + 12'(k));
        bus.pauseIn = 1'b0;
        tick();
        tick();
        chk("af_hyst_occ2", almostFullP[2], 1);
        tick();
        chk("af_clear_occ1", almostFullP[2], 0);
        chk("full_clear", fullP[2], 0);
        wait_drain("fill_drain");

        // Back-pressure: five paused cycles with P1 pending, then release.
        bus.pauseIn = 1'b1;
        bus.pushIn = 4'b0010;
        bus.dataInputP1 = 12'h1C1;
        tick();
        bus.pushIn = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("pause_no_pop", bus.pushOut, 0);
        end
        chk("pause_data_hold", bus.dataOutputFIFO, 12'h2A3);
        sb.push_back(12'h1C1);
        bus.pauseIn = 1'b0;
        tick();
        chk("release_pushOut", bus.pushOut, 1);
        chk("release_data", bus.dataOutputFIFO, 12'h1C1);
        wait_drain("pause_drain");

        // Reset with three words queued: they must never come out.
        bus.pauseIn = 1'b1;
        bus.pushIn = 4'b0111;
        bus.dataInputP0 = 12'hD00; bus.dataInputP1 = 12'hD11; bus.dataInputP2 = 12'hD22;
        tick();
        bus.pushIn = '0;
        reset = 1'b1;
        bus.pauseIn = 1'b0;
        tick();
        chk("mid_rst_pushOut", bus.pushOut, 0);
        chk("mid_rst_fullP", fullP, 0);
        chk("mid_rst_error", errorOut, 0);
        chk("mid_rst_data", bus.dataOutputFIFO, 0);
        tick();
        reset = 1'b0;
        tick();
        do_init();
        chk("mid_rst_idle", idleOut, 1);
        for (int k = 0; k < 4; k++) tick();
        chk("mid_rst_empty", idleOut, 1);
        for (int k = 0; k < 4; k++) read_cnt("cnt_zero", 3'(k), 5'd0);
        req = 1'b0;

        // 33 pops of P3 wrap its counter to 1.
        for (int k = 0; k < 33; k++) begin
            bus.pushIn = 4'b1000;
            bus.dataInputP3 = 12'h300 + 12'(k);
            sb.push_back(12'h300 + 12'(k));
            tick();
        end
        bus.pushIn = '0;
        wait_drain("stream_drain");
        for (int i = 0; i < 5; i++) read_cnt("cnt_tbl", rt[i].idx, rt[i].cnt);
        req = 1'b0;
        tick();
        chk("req_low_valid", counterValid, 0);

        // Read on the same edge as a P3 pop returns the pre-increment value.
        bus.pushIn = 4'b1000;
        bus.dataInputP3 = 12'h3EE;
        sb.push_back(12'h3EE);
        tick();
        bus.pushIn = '0;
        read_cnt("cnt_pre_inc", 3'd3, 5'd1);
        read_cnt("cnt_post_inc", 3'd3, 5'd2);
        req = 1'b0;
        wait_drain("pre_inc_drain");

        init = 1'b1;
        tick();
        req = 1'b1;
        idx = 3'd3;
        tick();
        chk("init_again_req", counterValid, 0);
        chk("init_again_idle", idleOut, 0);
        req = 1'b0;
        init = 1'b0;
        tick();
        chk("final_idle", idleOut, 1);
        chk("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tcl_tx_merge.md
Name: tcl_tx_merge

Overview:
Transmit side of the transaction layer: the 4-to-1 merge that mirrors the receive-side 1-to-4 split.
- Four upstream virtual-channel sources (P0..P3) each push 12-bit words into a private FIFO.
- A round-robin arbiter drains the FIFOs into a single 12-bit output stream toward the link FIFO, honouring downstream back-pressure.
- Per-port almost-full flags use programmable Umbral_alto/Umbral_bajo thresholds with hysteresis.
- Per-port sent-word counters are read through the same req/idx/counterOut handshake the receive side uses.

Parameters:
DATA_W, 12, word width
DEPTH, 4, per-port FIFO depth (power of 2, max 7)
CNT_W, 5, width of each sent-word counter

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-high
init  input  1  high: (re)enter INIT and latch thresholds
Umbral_alto  input  3  almost-full set threshold (occupancy)
Umbral_bajo  input  3  almost-full clear threshold (occupancy)
pushIn  input  4  per-port push strobe, bit i = Pi
dataInputP0..dataInputP3  input  DATA_W each  per-port write data
pauseIn  input  1  downstream almost-full; no pop while high
pushOut  output  1  registered valid for dataOutputFIFO
dataOutputFIFO  output  DATA_W  registered merged word
fullP  output  4  bit i: FIFO i occupancy == DEPTH
almostFullP  output  4  bit i: hysteretic threshold flag
errorOut  output  1  sticky: push to a full FIFO occurred
idleOut  output  1  high in IDLE state
req  input  1  counter read request
idx  input  3  counter select: 0..3 = P0..P3
counterValid  output  1  registered, counterOut valid
counterOut  output  CNT_W  registered counter value

Behaviour:
- Reset (reset=1 at an edge): FSM=RESET; all FIFOs empty; RR pointer=3, so P0 wins first; counters=0. Outputs: pushOut=0, dataOutputFIFO=0, fullP=0, almostFullP=0, errorOut=0, idleOut=0, counterValid=0, counterOut=0. Reset mid-transfer discards all queued data.
- FSM transitions:
  - RESET->INIT on the first edge with reset=0.
  - INIT: latches Umbral_alto/Umbral_bajo every cycle. INIT->IDLE when init=0.
  - IDLE->ACTIVE when any FIFO is non-empty. ACTIVE->IDLE when all FIFOs are empty and no pop occurs this cycle.
  - IDLE/ACTIVE->INIT when init=1. Queued data is kept, but nothing is popped in INIT.
- Push:
  - Accepted in any state except RESET when fullP[i]=0.
  - Push when full: the word is dropped and errorOut is set. This holds even if the same port is popped that cycle.
  - Push to an empty FIFO is legal in the same cycle as any pop.
- Arbitration (IDLE or ACTIVE, pauseIn=0): the grant goes to the first non-empty port searching from ptr+1 mod 4 upward. The winner is popped and ptr takes the winner's index.
  - Next cycle: pushOut=1 and dataOutputFIFO=popped word, unmodified.
  - With no pop, pushOut=0 and dataOutputFIFO holds its last value.
  - Latency: word pushed at edge N appears on the output after edge N+1 when its port wins.
- Back-pressure: pauseIn is sampled at the pop edge. pauseIn=1 means no pop, and ptr is unchanged.
- Flags:
  - fullP is registered from the next occupancy.
  - almostFullP[i] sets when occupancy >= Umbral_alto and clears when occupancy <= Umbral_bajo; otherwise it holds.
  - If Umbral_bajo >= Umbral_alto, the set condition wins.
- Counters: counter i increments on each pop of Pi and wraps 31->0. Increments happen only in IDLE/ACTIVE.
- Counter read: req=1 at edge N gives counterValid=1 and counterOut=cnt[idx] after edge N.
  - idx 4..7 returns counterOut=0 with counterValid=1.
  - req=0 gives counterValid=0.
  - req in RESET/INIT gives counterValid=0.
  - A same-cycle pop increment is not reflected in the returned value (pre-increment value).

Optional Feature:
TCL_TX_STRICT_PRIO_EN
- Defined: fixed priority P0>P1>P2>P3; the RR pointer is removed.
- Undefined: round-robin as above.
- All other behaviour is identical.

Decomposition:
- Package tcl_pkg: DATA_W, NUM_PORTS=4, CNT_W, FSM state encoding (RESET, INIT, IDLE, ACTIVE).
- Sub-module tcl_tx_fifo, instantiated 4 times: synchronous FIFO exposing push, pop, data, occupancy, full, empty. The drop-on-full rule lives inside it.
- Arbiter, flags, counters and FSM sit in the top module.

Test Plan:
- Reset, then init=1 with alto=3, bajo=1 for 2 cycles, then init=0 -> idleOut=1, all outputs 0.
- Push 0x101, 0x202, 0x303, 0x404 simultaneously on P0..P3, pauseIn=0 -> output order 0x101, 0x202, 0x303, 0x404 on 4 consecutive pushOut cycles; idleOut returns to 1.
- Fill P2 with 4 words, then push 5th -> fullP[2]=1, errorOut=1, almostFullP[2] set at occupancy 3; drain to 1 -> almostFullP[2]=0.
- Hold pauseIn=1 for 5 cycles with P1 non-empty -> pushOut=0 throughout; release -> P1 word appears after the next edge.
- Pop P3 33 times, then req=1, idx=3 -> counterValid=1, counterOut=1; idx=5 -> counterOut=0.
- Assert reset mid-stream with 3 words queued -> next cycle pushOut=0, FIFOs empty, counters 0; with TCL_TX_STRICT_PRIO_EN, P0 always wins when non-empty.
